// File: rtl/gates_pairwise_pkg.sv
// ---------------------------------------------------------------------------
// gates_pairwise_pkg
//
// Purpose : Shared types and helpers for the pairwise bit-gate pipeline.
//           Defines the op select encoding and the single-bit gate function
//           used by the combinational core.
//
// Contents:
//   op_t      2-bit op select: AND, OR, XNOR, XOR
//   apply_op  evaluates one gate on a pair of bits
// ---------------------------------------------------------------------------
package gates_pairwise_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XNOR = 2'b10,
    OP_XOR  = 2'b11
  } op_t;

  // Single-bit gate selected by op.
  function automatic logic apply_op(op_t op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XNOR: r = ~(a ^ b);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gates_pairwise_comb.sv
// ---------------------------------------------------------------------------
// gates_pairwise_comb
//
// Purpose : Purely combinational pairwise gate array.
//           result[i] = OP(in_msg[i], in_msg[i+1]) for i = 0..NBITS-2.
//
// Parameters:
//   NBITS   input width (>= 2); result is NBITS-1 bits wide
//
// Ports:
//   in_msg  in   NBITS     operand bits
//   in_op   in   op_t      gate select
//   result  out  NBITS-1   pairwise result
// ---------------------------------------------------------------------------
module gates_pairwise_comb
  import gates_pairwise_pkg::*;
#(
  parameter int NBITS = 100
) (
  input  logic [NBITS-1:0] in_msg,
  input  op_t              in_op,
  output logic [NBITS-2:0] result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < NBITS - 1; i++) begin
      result[i] = apply_op(in_op, in_msg[i], in_msg[i+1]);
    end
  end

endmodule

// File: rtl/gates_pairwise_pipe.sv
// ---------------------------------------------------------------------------
// gates_pairwise_pipe
//
// Purpose : Two-stage pipelined pairwise bit-gate unit with val/rdy
//           handshakes on both sides and a completed-transfer counter.
//           S0 registers the incoming message and op; the combinational
//           core sits between S0 and S1; S1 registers the result.
//
// Parameters:
//   NBITS   input message width (>= 2); output width is NBITS-1
//   CNTW    width of out_count
//
// Ports:
//   clk        in   1         clock, posedge
//   reset      in   1         asynchronous, active-high reset
//   in_val     in   1         input valid
//   in_rdy     out  1         input ready
//   in_msg     in   NBITS     operand bits
//   in_op      in   2         00 AND, 01 OR, 10 XNOR, 11 XOR
//   out_val    out  1         output valid
//   out_rdy    in   1         consumer ready
//   out_msg    out  NBITS-1   pairwise result
//   out_op     out  2         op that produced out_msg
//   out_count  out  CNTW      completed output transfers, wrapping
//   out_ones   out  clog2(NBITS)  popcount of out_msg
//                             (only with GATES_PAIRWISE_POPCNT_EN defined)
//
// Build option:
//   GATES_PAIRWISE_POPCNT_EN  adds the registered out_ones port.
// ---------------------------------------------------------------------------
module gates_pairwise_pipe
  import gates_pairwise_pkg::*;
#(
  parameter int NBITS = 100,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [NBITS-1:0]          in_msg,
  input  logic [1:0]                in_op,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [NBITS-2:0]          out_msg,
  output logic [1:0]                out_op,
`ifdef GATES_PAIRWISE_POPCNT_EN
  output logic [$clog2(NBITS)-1:0]  out_ones,
`endif
  output logic [CNTW-1:0]           out_count
);

  logic             s0_val;
  logic [NBITS-1:0] s0_msg;
  op_t              s0_op;

  logic             s1_val;
  logic [NBITS-2:0] s1_msg;
  op_t              s1_op;

  logic [CNTW-1:0]  count;
  logic [NBITS-2:0] comb_result;
  logic             s1_go;

  // S1 can take new data when empty or when its current content leaves
  // this cycle; S0 can likewise refill when empty or when it moves to S1.
  // Neither ready depends on the valid of the same side.
  assign s1_go  = !s1_val || out_rdy;
  assign in_rdy = !s0_val || s1_go;

  gates_pairwise_comb #(
    .NBITS (NBITS)
  ) u_comb (
    .in_msg (s0_msg),
    .in_op  (s0_op),
    .result (comb_result)
  );

  // Input stage: data loads only on an actual input transfer, so a bubble
  // leaves the last message in place without affecting the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_val <= 1'b0;
      s0_msg <= '0;
      s0_op  <= OP_AND;
    end else if (in_rdy) begin
      s0_val <= in_val;
      if (in_val) begin
        s0_msg <= in_msg;
        s0_op  <= op_t'(in_op);
      end
    end
  end

  // Output stage: holds bit-for-bit while stalled (s1_go low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val <= 1'b0;
      s1_msg <= '0;
      s1_op  <= OP_AND;
    end else if (s1_go) begin
      s1_val <= s0_val;
      if (s0_val) begin
        s1_msg <= comb_result;
        s1_op  <= s0_op;
      end
    end
  end

  // Completed-transfer counter; natural wrap at 2^CNTW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (s1_val && out_rdy) begin
      count <= count + 1'b1;
    end
  end

  assign out_val   = s1_val;
  assign out_msg   = s1_msg;
  assign out_op    = s1_op;
  assign out_count = count;

`ifdef GATES_PAIRWISE_POPCNT_EN
  localparam int ONESW = $clog2(NBITS);

  logic [ONESW-1:0] ones_next;
  logic [ONESW-1:0] s1_ones;

  // At most NBITS-1 ones, which always fits in clog2(NBITS) bits.
  always_comb begin
    ones_next = '0;
    for (int i = 0; i < NBITS - 1; i++) begin
      ones_next = ones_next + ONESW'(comb_result[i]);
    end
  end

  // Travels with s1_msg so it shares latency and stall behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ones <= '0;
    end else if (s1_go && s0_val) begin
      s1_ones <= ones_next;
    end
  end

  assign out_ones = s1_ones;
`endif

endmodule

// File: tb/tb_gates_pairwise_pipe.sv
// ---------------------------------------------------------------------------
// tb_gates_pairwise_pipe
//
// Purpose : Self-checking bench for gates_pairwise_pipe (NBITS = 100).
//           A negedge monitor keeps a queue of expected results computed
//           from whole-vector operations and compares every valid output
//           against its head; directed steps add latency, stall, reset and
//           counter checks. Also exercises out_ones when
//           GATES_PAIRWISE_POPCNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_gates_pairwise_pipe;

  localparam int NBITS = 100;
  localparam int CNTW  = 16;

  typedef struct packed {
    logic [NBITS-2:0] msg;
    logic [1:0]       op;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_val;
  logic              in_rdy;
  logic [NBITS-1:0]  in_msg;
  logic [1:0]        in_op;
  logic              out_val;
  logic              out_rdy;
  logic [NBITS-2:0]  out_msg;
  logic [1:0]        out_op;
  logic [CNTW-1:0]   out_count;
`ifdef GATES_PAIRWISE_POPCNT_EN
  logic [$clog2(NBITS)-1:0] out_ones;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   model_count = 0;
  logic rand_rdy = 1'b0;
  exp_t exp_q[$];

  gates_pairwise_pipe #(
    .NBITS (NBITS),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .in_op     (in_op),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .out_op    (out_op),
`ifdef GATES_PAIRWISE_POPCNT_EN
    .out_ones  (out_ones),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-vector pairwise gate (bit i with bit i+1).
  function automatic logic [NBITS-2:0] model(logic [NBITS-1:0] m, logic [1:0] op);
    logic [NBITS-2:0] a;
    logic [NBITS-2:0] b;
    logic [NBITS-2:0] r;
    a = m[NBITS-2:0];
    b = m[NBITS-1:1];
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a ^ b);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [127:0] observed, logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer one transaction and hold it until accepted (bounded). Returns
  // 1 time unit after the accepting edge.
  task automatic applyStimulus(logic [NBITS-1:0] msg, logic [1:0] op);
    int   budget;
    logic acc;
    in_val = 1'b1;
    in_msg = msg;
    in_op  = op;
    budget = 0;
    do begin
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) checkOutput("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic doReset();
    in_val = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
  endtask

  function automatic logic [NBITS-1:0] rand_msg();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[NBITS-1:0];
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      checkOutput("out_count", 128'(out_count), 128'(model_count[CNTW-1:0]));
      if (exp_q.size() == 0) begin
        checkOutput("spurious_val", 128'(out_val), 128'(0));
      end else if (out_val) begin
        checkOutput("out_msg", 128'(out_msg), 128'(exp_q[0].msg));
        checkOutput("out_op", 128'(out_op), 128'(exp_q[0].op));
`ifdef GATES_PAIRWISE_POPCNT_EN
        checkOutput("out_ones", 128'(out_ones), 128'($countones(exp_q[0].msg)));
`endif
        if (out_rdy) begin
          void'(exp_q.pop_front());
          model_count++;
        end
      end
      if (in_val && in_rdy) exp_q.push_back('{msg: model(in_msg, in_op), op: in_op});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NBITS-2:0] t2_exp[4];
    logic [1:0]       t2_op[4];
    int               start;
    logic [NBITS-1:0] ones;

    t2_op[0] = 2'b00; t2_exp[0] = 99'h1;
    t2_op[1] = 2'b01; t2_exp[1] = 99'h3;
    t2_op[2] = 2'b11; t2_exp[2] = 99'h2;
    t2_op[3] = 2'b10; t2_exp[3] = 99'h7_ffff_ffff_ffff_ffff_ffff_fffd;

    // 1. Reset asserted with in_val high.
    reset   = 1'b1;
    in_val  = 1'b1;
    in_msg  = rand_msg();
    in_op   = 2'b01;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_val", 128'(out_val), 128'(0));
    checkOutput("rst_in_rdy", 128'(in_rdy), 128'(1));
    checkOutput("rst_out_count", 128'(out_count), 128'(0));
    checkOutput("rst_out_msg", 128'(out_msg), 128'(0));
    checkOutput("rst_out_op", 128'(out_op), 128'(0));
    @(posedge clk);
    #1;
    in_val = 1'b0;
    reset  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 128'(out_val), 128'(0));
    end
    @(posedge clk);
    #1;

    // 2. in_msg = 3 with each op; output valid two edges after acceptance.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(100'h3, t2_op[i]);
      in_val = 1'b0;
      @(negedge clk);
      checkOutput("t2_not_early", 128'(out_val), 128'(0));
      @(negedge clk);
      checkOutput("t2_val", 128'(out_val), 128'(1));
      checkOutput("t2_msg", 128'(out_msg), 128'(t2_exp[i]));
      @(posedge clk);
      #1;
    end

    // 3. Back-pressure: two accepted, third blocked, output held.
    doReset();
    out_rdy = 1'b0;
    applyStimulus(100'h1, 2'b01);
    applyStimulus(100'h2, 2'b01);
    in_val = 1'b1;
    in_msg = 100'h4;
    in_op  = 2'b01;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t3_in_rdy_low", 128'(in_rdy), 128'(0));
      checkOutput("t3_held_val", 128'(out_val), 128'(1));
      checkOutput("t3_held_msg", 128'(out_msg), 128'(99'h1));
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    applyStimulus(100'h4, 2'b01);
    in_val = 1'b0;
    @(negedge clk);
    checkOutput("t3_second", 128'(out_msg), 128'(99'h3));
    @(negedge clk);
    checkOutput("t3_third", 128'(out_msg), 128'(99'h6));
    repeat (3) @(negedge clk);
    checkOutput("t3_count", 128'(out_count), 128'(3));
    checkOutput("t3_drained", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;

    // 4. Eight back-to-back random transactions at full rate.
    doReset();
    out_rdy = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++) applyStimulus(rand_msg(), 2'($urandom_range(0, 3)));
    checkOutput("t4_throughput", 128'(cyc - start), 128'(8));
    in_val = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t4_count", 128'(out_count), 128'(8));
    checkOutput("t4_drained", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;

    // 5. Reset with two transactions in flight (count is 8 going in).
    out_rdy = 1'b0;
    applyStimulus(rand_msg(), 2'($urandom_range(0, 3)));
    applyStimulus(rand_msg(), 2'($urandom_range(0, 3)));
    in_val = 1'b0;
    @(negedge clk);
    checkOutput("t5_in_flight", 128'(out_val), 128'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_val", 128'(out_val), 128'(0));
    checkOutput("t5_async_count", 128'(out_count), 128'(0));
    checkOutput("t5_async_rdy", 128'(in_rdy), 128'(1));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    out_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t5_no_stale", 128'(out_val), 128'(0));
    end
    checkOutput("t5_count", 128'(out_count), 128'(0));
    @(posedge clk);
    #1;

`ifdef GATES_PAIRWISE_POPCNT_EN
    // 6a. All ones AND gives 99 ones.
    ones = '1;
    applyStimulus(ones, 2'b00);
    in_val = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6_ones", 128'(out_ones), 128'(99));
    @(posedge clk);
    #1;
`else
    ones = '0;
`endif

    // 6b. 200 random transactions with random consumer back-pressure.
    doReset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) applyStimulus(rand_msg() | ones, 2'($urandom_range(0, 3)));
    rand_rdy = 1'b0;
    in_val   = 1'b0;
    out_rdy  = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t6_count", 128'(out_count), 128'(200));
    checkOutput("t6_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
